// File: rtl/lift_car_controller_if.sv
// Dispatcher <-> car controller signal bundle.
// The dispatcher side drives the stop vector; the car side reports its
// position, motion, door state and per-floor service pulses.
interface lift_car_controller_if;
  logic [10:0] FloortoLift;
  logic [3:0]  liftstate;
  logic        moving;
  logic        dir_up;
  logic        door_open;
  logic [10:0] served;

  modport slave (
    input  FloortoLift,
    output liftstate,
    output moving,
    output dir_up,
    output door_open,
    output served
  );

  modport master (
    output FloortoLift,
    input  liftstate,
    input  moving,
    input  dir_up,
    input  door_open,
    input  served
  );
endinterface

// File: rtl/lift_car_controller.sv
// Per-car motion and door controller.
// Latches rising edges of the dispatcher stop vector, serves the stops in
// SCAN order, times floor-to-floor travel and door dwell, and pulses a
// one-hot served vector whenever a floor is serviced.
module lift_car_controller #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  lift_car_controller_if.slave bus
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LOAD   = TW'(DOOR_CYCLES - 1);
  localparam logic [3:0]    TOP_FLOOR   = 4'd10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [10:0]     req_q;
  logic [10:0]     pending_q, pending_d;
  logic [3:0]      floor_q, floor_d;
  logic            dir_q, dir_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [10:0]     served_q, served_d;
  logic            moving_q, door_open_q;

  logic [10:0]     new_s;
  logic [10:0]     here_bit_s;
  logic            above_s, below_s, here_s;
  logic [3:0]      next_floor_s;
  logic [10:0]     next_bit_s;

  // One-hot mask selecting floor f (all zero for f outside 0..10).
  function automatic logic [10:0] floor_bit(input logic [3:0] f);
    logic [10:0] b;
    for (int i = 0; i < 11; i++) begin
      b[i] = (int'(f) == i);
    end
    return b;
  endfunction

  // True when any pending stop lies strictly above floor f.
  function automatic logic any_above(input logic [10:0] p, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > int'(f)) begin
        r = r | p[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // True when any pending stop lies strictly below floor f.
  function automatic logic any_below(input logic [10:0] p, input logic [3:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i < int'(f)) begin
        r = r | p[i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  assign new_s      = bus.FloortoLift & ~req_q;
  assign here_bit_s = floor_bit(floor_q);
  assign here_s     = |(pending_q & here_bit_s);
  assign above_s    = any_above(pending_q, floor_q);
  assign below_s    = any_below(pending_q, floor_q);

  // Floor the car reaches when the current travel leg completes (saturating).
  always_comb begin
    next_floor_s = floor_q;
    if (state_q == MOVE_UP) begin
      next_floor_s = (floor_q < TOP_FLOOR) ? floor_q + 4'd1 : floor_q;
    end else if (state_q == MOVE_DOWN) begin
      next_floor_s = (floor_q > 4'd0) ? floor_q - 4'd1 : floor_q;
    end else begin
      next_floor_s = floor_q;
    end
    next_bit_s = floor_bit(next_floor_s);
  end

  // Next-state, timer, direction and service decisions for the car.
  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    served_d = 11'h000;
    case (state_q)
      IDLE: begin
        if (here_s) begin
          state_d  = DOOR;
          served_d = here_bit_s;
          timer_d  = DOOR_LOAD;
        end else if (dir_q && above_s) begin
          state_d = MOVE_UP;
          timer_d = TRAVEL_LOAD;
        end else if (below_s) begin
          state_d = MOVE_DOWN;
          dir_d   = 1'b0;
          timer_d = TRAVEL_LOAD;
        end else if (above_s) begin
          state_d = MOVE_UP;
          dir_d   = 1'b1;
          timer_d = TRAVEL_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else begin
          floor_d = next_floor_s;
          if (|(pending_q & next_bit_s)) begin
            state_d  = DOOR;
            served_d = next_bit_s;
            timer_d  = DOOR_LOAD;
          end else if ((state_q == MOVE_UP) ? any_above(pending_q, next_floor_s)
                                            : any_below(pending_q, next_floor_s)) begin
            timer_d = TRAVEL_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DOOR: begin
        // A fresh request for this floor while the door is open is served
        // on the spot and keeps the door open for a full dwell again.
        if (|(new_s & here_bit_s)) begin
          served_d = here_bit_s;
          timer_d  = DOOR_LOAD;
        end else if (timer_q == '0) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Service wins over a coincident new edge on the same floor.
    pending_d = (pending_q | new_s) & ~served_d;
  end

  // State, position, timer, stop bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      req_q       <= 11'h000;
      pending_q   <= 11'h000;
      floor_q     <= 4'd0;
      dir_q       <= 1'b1;
      timer_q     <= '0;
      served_q    <= 11'h000;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= bus.FloortoLift;
      pending_q   <= pending_d;
      floor_q     <= floor_d;
      dir_q       <= dir_d;
      timer_q     <= timer_d;
      served_q    <= served_d;
      moving_q    <= (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
      door_open_q <= (state_d == DOOR);
    end
  end

  assign bus.liftstate = floor_q;
  assign bus.moving    = moving_q;
  assign bus.dir_up    = dir_q;
  assign bus.door_open = door_open_q;
  assign bus.served    = served_q;

endmodule

// File: tb/tb_lift_car_controller.sv
// Directed self-checking bench for lift_car_controller
// (TRAVEL_CYCLES = 8, DOOR_CYCLES = 16).
module tb_lift_car_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  lift_car_controller_if bus();

  lift_car_controller #(
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.FloortoLift = 11'h000;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Wait (bounded) for the next served pulse; returns 0 on timeout.
  task automatic wait_served(input int budget, output logic [10:0] v);
    int waited;
    waited = 0;
    while (bus.served === 11'h000 && waited < budget) begin
      tick();
      waited++;
    end
    v = bus.served;
  endtask

  task automatic test_reset();
    logic [10:0] v;
    logic [10:0] exp;
    rst = 1'b0;
    bus.FloortoLift = 11'h7FF;
    repeat (3) tick();
    vectors++;
    if ({bus.liftstate, bus.moving, bus.door_open, bus.served, bus.dir_up} !==
        {4'd0, 1'b0, 1'b0, 11'h000, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: floor=%0d mv=%b door=%b srv=%h dir=%b, want 0 0 0 000 1",
               bus.liftstate, bus.moving, bus.door_open, bus.served, bus.dir_up);
    end
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.served !== 11'h001 || bus.door_open !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_stop: srv=%h door=%b, want 001 1", bus.served, bus.door_open);
    end
    tick();
    for (int k = 1; k <= 10; k++) begin
      exp = 11'h001 << k;
      wait_served(60, v);
      vectors++;
      if (v !== exp || bus.liftstate !== 4'(k)) begin
        errors++;
        $display("FAIL reset_all_edges: srv=%h floor=%0d, want %h %0d", v, bus.liftstate, exp, k);
      end
      tick();
    end
    bus.FloortoLift = 11'h000;
    repeat (20) tick();
  endtask

  task automatic test_local_stop();
    int  door_cnt;
    int  extra;
    bit  done;
    do_reset();
    bus.FloortoLift = 11'h001;
    tick();
    tick();
    vectors++;
    if (bus.served !== 11'h001 || bus.door_open !== 1'b1) begin
      errors++;
      $display("FAIL local_serve: srv=%h door=%b, want 001 1", bus.served, bus.door_open);
    end
    door_cnt = 1;
    extra = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (bus.served !== 11'h000) extra++;
      if (bus.door_open === 1'b1) door_cnt++;
      else done = 1'b1;
    end
    vectors++;
    if (door_cnt !== 16) begin
      errors++;
      $display("FAIL local_door_len: got %0d cycles, want 16", door_cnt);
    end
    vectors++;
    if (bus.moving !== 1'b0 || bus.door_open !== 1'b0) begin
      errors++;
      $display("FAIL local_idle: mv=%b door=%b, want 0 0", bus.moving, bus.door_open);
    end
    repeat (30) begin
      tick();
      if (bus.served !== 11'h000 || bus.door_open !== 1'b0) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL local_no_reserve: %0d extra service cycles, want 0", extra);
    end
    bus.FloortoLift = 11'h000;
  endtask

  task automatic test_travel();
    int mov;
    do_reset();
    bus.FloortoLift = 11'h008;
    tick();
    tick();
    vectors++;
    if (bus.moving !== 1'b1 || bus.liftstate !== 4'd0) begin
      errors++;
      $display("FAIL travel_start: mv=%b floor=%0d, want 1 0", bus.moving, bus.liftstate);
    end
    mov = 1;
    for (int i = 1; i <= 24; i++) begin
      tick();
      if (bus.moving === 1'b1) mov++;
      if (i == 7 || i == 8 || i == 15 || i == 16) begin
        vectors++;
        if (bus.liftstate !== 4'(i / 8)) begin
          errors++;
          $display("FAIL travel_step: cycle %0d floor=%0d, want %0d", i, bus.liftstate, i / 8);
        end
      end
    end
    vectors++;
    if (bus.liftstate !== 4'd3 || bus.served !== 11'h008 || bus.door_open !== 1'b1) begin
      errors++;
      $display("FAIL travel_arrive: floor=%0d srv=%h door=%b, want 3 008 1",
               bus.liftstate, bus.served, bus.door_open);
    end
    vectors++;
    if (mov !== 24) begin
      errors++;
      $display("FAIL travel_moving_len: got %0d, want 24", mov);
    end
    bus.FloortoLift = 11'h000;
    repeat (20) tick();
  endtask

  task automatic test_scan();
    logic [10:0] v;
    logic [10:0] exp_srv [3];
    logic [3:0]  exp_flr [3];
    exp_srv[0] = 11'h010; exp_flr[0] = 4'd4;
    exp_srv[1] = 11'h040; exp_flr[1] = 4'd6;
    exp_srv[2] = 11'h002; exp_flr[2] = 4'd1;
    do_reset();
    bus.FloortoLift = 11'h040;
    tick();
    repeat (12) tick();
    vectors++;
    if (bus.liftstate !== 4'd1 || bus.moving !== 1'b1) begin
      errors++;
      $display("FAIL scan_midway: floor=%0d mv=%b, want 1 1", bus.liftstate, bus.moving);
    end
    bus.FloortoLift = 11'h052;
    for (int k = 0; k < 3; k++) begin
      wait_served(150, v);
      vectors++;
      if (v !== exp_srv[k] || bus.liftstate !== exp_flr[k]) begin
        errors++;
        $display("FAIL scan_order: stop %0d srv=%h floor=%0d, want %h %0d",
                 k, v, bus.liftstate, exp_srv[k], exp_flr[k]);
      end
      tick();
    end
    vectors++;
    if (bus.dir_up !== 1'b0) begin
      errors++;
      $display("FAIL scan_reverse_dir: dir_up=%b, want 0", bus.dir_up);
    end
    bus.FloortoLift = 11'h000;
    repeat (20) tick();
  endtask

  task automatic test_door_extension();
    int  door_cnt;
    int  waited;
    bit  done;
    do_reset();
    bus.FloortoLift = 11'h020;
    waited = 0;
    while (bus.door_open !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    vectors++;
    if (bus.served !== 11'h020 || bus.liftstate !== 4'd5) begin
      errors++;
      $display("FAIL ext_arrive: srv=%h floor=%0d, want 020 5", bus.served, bus.liftstate);
    end
    bus.FloortoLift = 11'h000;
    door_cnt = 1;
    repeat (9) begin
      tick();
      if (bus.door_open === 1'b1) door_cnt++;
    end
    bus.FloortoLift = 11'h020;
    tick();
    if (bus.door_open === 1'b1) door_cnt++;
    vectors++;
    if (bus.served !== 11'h020) begin
      errors++;
      $display("FAIL ext_second_serve: srv=%h, want 020", bus.served);
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      tick();
      if (bus.door_open === 1'b1) door_cnt++;
      else done = 1'b1;
    end
    vectors++;
    if (door_cnt !== 26) begin
      errors++;
      $display("FAIL ext_door_len: got %0d cycles, want 26", door_cnt);
    end
    bus.FloortoLift = 11'h000;
    repeat (5) tick();
  endtask

  task automatic test_async_reset();
    int bad;
    do_reset();
    bus.FloortoLift = 11'h200;
    tick();
    repeat (20) tick();
    vectors++;
    if (bus.liftstate !== 4'd2 || bus.moving !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: floor=%0d mv=%b, want 2 1", bus.liftstate, bus.moving);
    end
    #2;
    rst = 1'b0;
    bus.FloortoLift = 11'h000;
    #1;
    vectors++;
    if ({bus.liftstate, bus.moving, bus.door_open, bus.served, bus.dir_up} !==
        {4'd0, 1'b0, 1'b0, 11'h000, 1'b1}) begin
      errors++;
      $display("FAIL areset_clear: floor=%0d mv=%b door=%b srv=%h dir=%b, want 0 0 0 000 1",
               bus.liftstate, bus.moving, bus.door_open, bus.served, bus.dir_up);
    end
    tick();
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      tick();
      if (bus.served !== 11'h000 || bus.moving !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL areset_lost_pending: %0d active cycles, want 0", bad);
    end
  endtask

  initial begin
    bus.FloortoLift = 11'h000;
    test_reset();
    test_local_stop();
    test_travel();
    test_scan();
    test_door_extension();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
